gen_scheduler: RTL and testbench

- Paces Game-of-Life generations against display frames.
- Issues one logic start per generation, waits for the logic to finish, then requests the double-buffer swap only at a frame boundary.
- Supports run, pause and single-step control, and flags logic overruns.
- Sits between user_interface, life_logic, renderer and double_buffer in place of the simple start/swap sequencer.

---
 rtl/gen_scheduler_pkg.sv | 18 +
 rtl/gen_scheduler_frame_pacer.sv | 28 ++
 rtl/gen_scheduler.sv | 133 +++++++++++++
 tb/tb_gen_scheduler.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gen_scheduler_pkg.sv
// Shared types for the generation scheduler: FSM state encoding and default widths.
package gen_scheduler_pkg;

  localparam int unsigned DefSpeedWidth = 4;
  localparam int unsigned DefGenWidth   = 16;

  typedef logic [DefSpeedWidth-1:0] speed_t;
  typedef logic [DefGenWidth-1:0]   gen_t;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StRun,
    StWaitSwap,
    StSwap
  } sched_state_t;

endpackage

// File: rtl/gen_scheduler_frame_pacer.sv
// Saturating frame counter; flags when enough frames have elapsed for the next generation.
module frame_pacer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             count_en,
  input  logic             clear,
  input  logic [WIDTH-1:0] speed,
  output logic             due
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (count_en && (cnt_q != '1)) begin
      cnt_q <= cnt_q + WIDTH'(1);
    end
  end

  // speed is compared live so a lowered setting takes effect immediately
  assign due = (cnt_q >= speed);

endmodule

// File: rtl/gen_scheduler.sv
// Paces Life generations against display frames: start, wait for logic, swap on a frame boundary.
// Optional logic watchdog enabled by defining GEN_SCHED_WATCHDOG_EN.
module gen_scheduler
  import gen_scheduler_pkg::*;
#(
  parameter int unsigned SPEED_WIDTH = DefSpeedWidth,
  parameter int unsigned GEN_WIDTH   = DefGenWidth,
  parameter int unsigned WDOG_FRAMES = 4
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   render_done_in,
  input  logic                   logic_done_in,
  input  logic                   buf_ready_in,
  input  logic [SPEED_WIDTH-1:0] speed_in,
  input  logic                   pause_in,
  input  logic                   step_in,
  output logic                   logic_start_out,
  output logic                   buf_swap_out,
  output logic                   busy_out,
  output logic [GEN_WIDTH-1:0]   gen_count_out,
  output logic                   overrun_out,
  output logic                   timeout_out
);

  sched_state_t         state_q, state_d;
  logic                 step_pend_q;
  logic [GEN_WIDTH-1:0] gen_q;
  logic                 overrun_q;
  logic                 frame_due;
  logic                 wdog_expire;

  frame_pacer #(
    .WIDTH(SPEED_WIDTH)
  ) u_frame_pacer (
    .clk     (clk_in),
    .rst     (rst_in),
    .count_en(render_done_in && (state_q == StIdle)),
    .clear   ((state_q == StSwap) || wdog_expire),
    .speed   (speed_in),
    .due     (frame_due)
  );

`ifdef GEN_SCHED_WATCHDOG_EN
  localparam int unsigned WdogW = $clog2(WDOG_FRAMES + 1);

  logic [WdogW-1:0] wdog_q;
  logic             timeout_q;

  assign wdog_expire = (state_q == StRun) && render_done_in && !logic_done_in &&
                       (wdog_q == WdogW'(WDOG_FRAMES - 1));

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state_q != StRun) begin
        wdog_q <= '0;
      end else if (render_done_in) begin
        wdog_q <= wdog_q + WdogW'(1);
      end
      if (wdog_expire) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign timeout_out = timeout_q;
`else
  logic unused_wdog;
  assign unused_wdog = ^WDOG_FRAMES;
  assign wdog_expire = 1'b0;
  assign timeout_out = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (buf_ready_in && ((frame_due && !pause_in) || step_pend_q)) begin
          state_d = StStart;
        end
      end
      StStart: state_d = StRun;
      StRun: begin
        // a frame boundary coinciding with logic_done counts as the swap boundary
        if (logic_done_in) begin
          state_d = (render_done_in && buf_ready_in) ? StSwap : StWaitSwap;
        end else if (wdog_expire) begin
          state_d = StIdle;
        end
      end
      StWaitSwap: begin
        if (render_done_in && buf_ready_in) begin
          state_d = StSwap;
        end
      end
      StSwap:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= StIdle;
      step_pend_q <= 1'b0;
      gen_q       <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == StStart) begin
        step_pend_q <= 1'b0;
      end else if (step_in && pause_in && (state_q == StIdle)) begin
        step_pend_q <= 1'b1;
      end
      if (state_q == StSwap) begin
        gen_q <= gen_q + GEN_WIDTH'(1);
      end
      if (render_done_in &&
          ((state_q == StStart) || ((state_q == StRun) && !logic_done_in))) begin
        overrun_q <= 1'b1;
      end
    end
  end

  assign logic_start_out = (state_q == StStart);
  assign buf_swap_out    = (state_q == StSwap);
  assign busy_out        = (state_q != StIdle);
  assign gen_count_out   = gen_q;
  assign overrun_out     = overrun_q;

endmodule

// File: tb/tb_gen_scheduler.sv
// Directed bench for gen_scheduler: per-cycle vector table plus multi-cycle sequences.
module tb_gen_scheduler;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        render_done_in = 1'b0;
  logic        logic_done_in = 1'b0;
  logic        buf_ready_in = 1'b0;
  logic [3:0]  speed_in = 4'd0;
  logic        pause_in = 1'b0;
  logic        step_in = 1'b0;
  logic        logic_start_out;
  logic        buf_swap_out;
  logic        busy_out;
  logic [15:0] gen_count_out;
  logic        overrun_out;
  logic        timeout_out;

  int checks = 0;
  int errors = 0;

  gen_scheduler dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .render_done_in (render_done_in),
    .logic_done_in  (logic_done_in),
    .buf_ready_in   (buf_ready_in),
    .speed_in       (speed_in),
    .pause_in       (pause_in),
    .step_in        (step_in),
    .logic_start_out(logic_start_out),
    .buf_swap_out   (buf_swap_out),
    .busy_out       (busy_out),
    .gen_count_out  (gen_count_out),
    .overrun_out    (overrun_out),
    .timeout_out    (timeout_out)
  );

  always #5 clk_in = ~clk_in;

  // {rd, ld, rdy, pause, step, speed} -> {start, swap, busy, overrun, timeout}, gen
  typedef struct {
    logic       rd;
    logic       ld;
    logic       rdy;
    logic       pause;
    logic       step;
    logic [3:0] speed;
    logic [4:0] flags;
    logic [15:0] gen;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  function automatic logic [31:0] flags();
    return {27'd0, logic_start_out, buf_swap_out, busy_out, overrun_out, timeout_out};
  endfunction

  task automatic do_reset();
    rst_in = 1'b1;
    render_done_in = 1'b0;
    logic_done_in  = 1'b0;
    step_in        = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    rst_in = 1'b0;
  endtask

  initial begin
    int start_at[$];
    int swap_at[$];
    int ld_at;
    int n_start;
    int n_swap;
    logic [15:0] g0;

    tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 5'b00000, 16'd0};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 5'b10100, 16'd0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 5'b00100, 16'd0};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 5'b00100, 16'd0};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 5'b01100, 16'd0};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 5'b00000, 16'd1};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1, 5'b00000, 16'd1};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1, 5'b00000, 16'd1};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd1, 5'b00000, 16'd1};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1, 5'b10100, 16'd1};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd1, 5'b00100, 16'd1};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1, 5'b00100, 16'd1};
    tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd1, 5'b01100, 16'd1};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1, 5'b00000, 16'd2};
    tbl[14] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1, 5'b00000, 16'd2};

    #1;
    do_reset();
    chk("reset_flags", flags(), 32'd0);
    chk("reset_gen", 32'(gen_count_out), 32'd0);

    // Vector table: one row per clock
    for (int i = 0; i < 15; i++) begin
      render_done_in = tbl[i].rd;
      logic_done_in  = tbl[i].ld;
      buf_ready_in   = tbl[i].rdy;
      pause_in       = tbl[i].pause;
      step_in        = tbl[i].step;
      speed_in       = tbl[i].speed;
      tick();
      chk($sformatf("vec%0d_flags", i), flags(), 32'(tbl[i].flags));
      chk($sformatf("vec%0d_gen", i), 32'(gen_count_out), 32'(tbl[i].gen));
    end

    // Free-running pacing: speed 2, frame every 20 cycles, logic 5 cycles after start
    do_reset();
    speed_in = 4'd2; pause_in = 1'b0; buf_ready_in = 1'b1; step_in = 1'b0;
    ld_at = -1;
    for (int c = 0; c < 170; c++) begin
      render_done_in = (c % 20 == 19);
      logic_done_in  = (c == ld_at);
      tick();
      if (logic_start_out) begin
        start_at.push_back(c);
        ld_at = c + 5;
      end
      if (buf_swap_out) swap_at.push_back(c);
    end
    render_done_in = 1'b0; logic_done_in = 1'b0;
    chk("pace_n_start", 32'(start_at.size()), 32'd3);
    chk("pace_n_swap", 32'(swap_at.size()), 32'd2);
    if (start_at.size() == 3) begin
      chk("pace_first_start", 32'(start_at[0]), 32'd40);
      chk("pace_spacing1", 32'(start_at[1] - start_at[0]), 32'd60);
      chk("pace_spacing2", 32'(start_at[2] - start_at[1]), 32'd60);
    end
    if (swap_at.size() == 2) begin
      chk("pace_swap0_cycle", 32'(swap_at[0]), 32'd59);
      chk("pace_swap1_cycle", 32'(swap_at[1]), 32'd119);
    end
    chk("pace_gen", 32'(gen_count_out), 32'd2);
    chk("pace_overrun", 32'(overrun_out), 32'd0);

    // Paused, two step pulses 5 cycles apart: only one generation
    do_reset();
    speed_in = 4'd0; pause_in = 1'b1; buf_ready_in = 1'b1;
    g0 = gen_count_out;
    n_start = 0; n_swap = 0; ld_at = -1;
    for (int c = 0; c < 40; c++) begin
      step_in        = (c == 0) || (c == 5);
      logic_done_in  = (c == ld_at);
      render_done_in = (c % 10 == 9);
      tick();
      if (logic_start_out) begin
        n_start++;
        ld_at = c + 5;
      end
      if (buf_swap_out) n_swap++;
    end
    step_in = 1'b0; render_done_in = 1'b0; logic_done_in = 1'b0;
    chk("step_n_start", 32'(n_start), 32'd1);
    chk("step_n_swap", 32'(n_swap), 32'd1);
    chk("step_gen", 32'(gen_count_out), 32'(g0 + 16'd1));

    // Late logic_done -> overrun; buf not ready at first boundary
    do_reset();
    speed_in = 4'd0; pause_in = 1'b0; buf_ready_in = 1'b1;
    tick();
    chk("ovr_start", 32'(logic_start_out), 32'd1);
    tick(); tick();
    render_done_in = 1'b1; tick(); render_done_in = 1'b0;
    chk("ovr_flag", 32'(overrun_out), 32'd1);
    logic_done_in = 1'b1; tick(); logic_done_in = 1'b0;
    tick();
    chk("ovr_wait_busy", flags(), 32'b00110);
    buf_ready_in = 1'b0; render_done_in = 1'b1; tick(); render_done_in = 1'b0;
    chk("notready_noswap", flags(), 32'b00110);
    buf_ready_in = 1'b1; tick();
    chk("ready_idle_noswap", 32'(buf_swap_out), 32'd0);
    render_done_in = 1'b1; tick(); render_done_in = 1'b0;
    chk("late_swap", 32'(buf_swap_out), 32'd1);
    tick();
    chk("late_gen", 32'(gen_count_out), 32'd1);
    tick(); tick();
    chk("restart_busy", 32'(busy_out), 32'd1);

    // Asynchronous reset mid-RUN
    #3;
    rst_in = 1'b1;
    #1;
    chk("async_rst_flags", flags(), 32'd0);
    chk("async_rst_gen", 32'(gen_count_out), 32'd0);
    speed_in = 4'd3; pause_in = 1'b0; buf_ready_in = 1'b1;
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    n_start = 0;
    for (int c = 0; c < 4; c++) begin
      render_done_in = (c < 2);
      tick();
      if (logic_start_out) n_start++;
    end
    render_done_in = 1'b0;
    chk("post_rst_no_start", 32'(n_start), 32'd0);
    speed_in = 4'd1;
    tick();
    chk("live_speed_start", 32'(logic_start_out), 32'd1);

`ifdef GEN_SCHED_WATCHDOG_EN
    do_reset();
    speed_in = 4'd0; pause_in = 1'b0; buf_ready_in = 1'b1;
    tick(); tick();
    n_swap = 0;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("wdog_pre_timeout%0d", c), 32'(timeout_out), 32'd0);
      render_done_in = 1'b1; tick(); render_done_in = 1'b0;
      if (buf_swap_out) n_swap++;
      if (c < 3) begin
        tick();
        if (buf_swap_out) n_swap++;
      end
    end
    chk("wdog_timeout", 32'(timeout_out), 32'd1);
    chk("wdog_idle", 32'(busy_out), 32'd0);
    chk("wdog_no_swap", 32'(n_swap), 32'd0);
    chk("wdog_gen", 32'(gen_count_out), 32'd0);
    tick();
    chk("wdog_restart", 32'(logic_start_out), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
